// File: rtl/cache_pkg.sv
// Shared types, default geometry and the byte-merge helper for the
// direct-mapped write-through data cache.
package cache_pkg;

   localparam int CACHE_WIDTH      = 32;
   localparam int CACHE_SETS       = 64;
   localparam int CACHE_LINE_WORDS = 4;

   // Address split for the default geometry: byte+word offset, index, tag.
   localparam int WORD_BITS   = $clog2(CACHE_LINE_WORDS);
   localparam int OFFSET_BITS = 2 + WORD_BITS;
   localparam int INDEX_BITS  = $clog2(CACHE_SETS);
   localparam int TAG_BITS    = CACHE_WIDTH - OFFSET_BITS - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Replace the bytes of word selected by be with the matching bytes of data.
   function automatic logic [31:0] merge_bytes(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [3:0]  be);
      logic [31:0] res;
      res = word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage of the cache: combinational read of one set,
// synchronous word/line writes, asynchronous clear of the valid bits.
module dcache_array
   import cache_pkg::*;
#(
   parameter int WIDTH      = CACHE_WIDTH,
   parameter int SETS       = CACHE_SETS,
   parameter int LINE_WORDS = CACHE_LINE_WORDS
) (
   input  logic                                                    clk,
   input  logic                                                    rst_n,
   input  logic [$clog2(SETS)-1:0]                                 index,
   input  logic [$clog2(LINE_WORDS)-1:0]                           rd_word,
   output logic                                                    rd_valid,
   output logic [WIDTH-2-$clog2(LINE_WORDS)-$clog2(SETS)-1:0]      rd_tag,
   output logic [WIDTH-1:0]                                        rd_data,
   input  logic                                                    wr_en,
   input  logic [$clog2(LINE_WORDS)-1:0]                           wr_word,
   input  logic [WIDTH-1:0]                                        wr_data,
   input  logic                                                    line_set,
   input  logic [WIDTH-2-$clog2(LINE_WORDS)-$clog2(SETS)-1:0]      line_tag
);

   localparam int TAG_W = WIDTH - 2 - $clog2(LINE_WORDS) - $clog2(SETS);

   logic [WIDTH-1:0] data_q [SETS][LINE_WORDS];
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [SETS-1:0]  valid_q;

   assign rd_valid = valid_q[index];
   assign rd_tag   = tag_q[index];
   assign rd_data  = data_q[index][rd_word];

   // NOTE: storage arrays carry no reset; the valid bits alone make stale
   // contents unreachable, and leaving them unreset lets them map to RAM.
   // NOTE: sequential state is always assigned with <= so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (wr_en)    data_q[index][wr_word] <= wr_data;
      if (line_set) tag_q[index]           <= line_tag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        valid_q        <= '0;
      else if (line_set) valid_q[index] <= 1'b1;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: hit detection, refill/write-through FSM,
// beat counter and main-memory handshake; drives the pipeline stall.
module dcache_ctrl
   import cache_pkg::*;
#(
   parameter int WIDTH      = CACHE_WIDTH,
   parameter int SETS       = CACHE_SETS,
   parameter int LINE_WORDS = CACHE_LINE_WORDS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read_m,
   input  logic             mem_write_m,
   input  logic [WIDTH-1:0] addr_m,
   input  logic [WIDTH-1:0] wdata_m,
   input  logic [3:0]       be_m,
   output logic [WIDTH-1:0] rdata_m,
   output logic             cache_stall,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [3:0]       mem_be,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata
);

   localparam int WORD_W   = $clog2(LINE_WORDS);
   localparam int INDEX_W  = $clog2(SETS);
   localparam int OFFSET_W = 2 + WORD_W;
   localparam int TAG_W    = WIDTH - OFFSET_W - INDEX_W;
   localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

   state_e            state_q;
   logic [WORD_W-1:0] beat_q;

   logic [WORD_W-1:0]  word_sel;
   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic               is_store, is_load, hit;
   logic               rd_valid;
   logic [TAG_W-1:0]   rd_tag;
   logic [WIDTH-1:0]   rd_data;
   logic               refill_ack, write_ack;
   logic               arr_wr_en, line_set;
   logic [WORD_W-1:0]  arr_wr_word;
   logic [WIDTH-1:0]   arr_wr_data;

   assign word_sel = addr_m[2 +: WORD_W];
   assign index    = addr_m[OFFSET_W +: INDEX_W];
   assign tag      = addr_m[WIDTH-1 -: TAG_W];

   // A simultaneous read and write request is handled as a store.
   assign is_store = mem_write_m;
   assign is_load  = mem_read_m & ~mem_write_m;
   assign hit      = rd_valid && (rd_tag == tag);

   assign refill_ack  = (state_q == REFILL) && mem_ack;
   assign write_ack   = (state_q == WRITE)  && mem_ack;
   assign arr_wr_en   = refill_ack | (write_ack & hit);
   assign arr_wr_word = refill_ack ? beat_q : word_sel;
   assign arr_wr_data = refill_ack ? mem_rdata : merge_bytes(rd_data, wdata_m, be_m);
   assign line_set    = refill_ack && (beat_q == LAST_BEAT);

   dcache_array #(
      .WIDTH      (WIDTH),
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .index    (index),
      .rd_word  (word_sel),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (arr_wr_en),
      .wr_word  (arr_wr_word),
      .wr_data  (arr_wr_data),
      .line_set (line_set),
      .line_tag (tag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (is_store) begin
                  state_q <= WRITE;
               end else if (is_load && !hit) begin
                  state_q <= REFILL;
                  beat_q  <= '0;
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  if (beat_q == LAST_BEAT) begin
                     state_q <= IDLE;
                     beat_q  <= '0;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            WRITE:   if (mem_ack) state_q <= DONE;
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no path leaves
   // a value unassigned, which would otherwise infer a latch.
   always_comb begin
      cache_stall = 1'b0;
      rdata_m     = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_be      = '0;
      case (state_q)
         IDLE: begin
            cache_stall = is_store | (is_load & ~hit);
            if (is_load && hit) rdata_m = rd_data;
         end
         REFILL: begin
            cache_stall = 1'b1;
            mem_req     = 1'b1;
            mem_addr    = {addr_m[WIDTH-1:OFFSET_W], beat_q, 2'b00};
         end
         WRITE: begin
            cache_stall = 1'b1;
            mem_req     = 1'b1;
            mem_we      = 1'b1;
            mem_addr    = addr_m;
            mem_wdata   = wdata_m;
            mem_be      = be_m;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed loads/stores against a small
// memory responder; a monitor checks memory beats and pipeline retirements.
module tb_dcache_ctrl;

   logic        clk;
   logic        rst_n;
   logic        mem_read_m, mem_write_m;
   logic [31:0] addr_m, wdata_m;
   logic [3:0]  be_m;
   logic [31:0] rdata_m;
   logic        cache_stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } beat_t;

   typedef struct {
      bit          load;
      logic [31:0] rdata;
   } ret_t;

   beat_t       exp_mem[$];
   ret_t        exp_ret[$];
   logic [31:0] img [logic [31:0]];
   int          lat;
   int          checks;
   int          failures;

   dcache_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_read_m  (mem_read_m),
      .mem_write_m (mem_write_m),
      .addr_m      (addr_m),
      .wdata_m     (wdata_m),
      .be_m        (be_m),
      .rdata_m     (rdata_m),
      .cache_stall (cache_stall),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_merge(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
      return r;
   endfunction

   // Main memory: acks the outstanding beat on its lat-th requested cycle.
   initial begin
      int cnt;
      cnt       = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mem_ack = 1'b0;
            cnt     = 0;
         end else begin
            if (mem_ack) begin
               mem_ack = 1'b0;
               cnt     = 0;
            end
            if (mem_req) begin
               cnt++;
               if (cnt >= lat) begin
                  mem_ack = 1'b1;
                  if (mem_we) begin
                     img[mem_addr] = mem_merge(img.exists(mem_addr) ? img[mem_addr] : 32'h0,
                                               mem_wdata, mem_be);
                  end else begin
                     mem_rdata = img.exists(mem_addr) ? img[mem_addr] : 32'h0;
                  end
               end
            end
         end
      end
   end

   // Monitor: compares accepted memory beats and retiring requests.
   initial begin
      beat_t b;
      ret_t  r;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && mem_req && mem_ack) begin
            check("mem_beat_expected", 32'(exp_mem.size() != 0), 32'd1);
            if (exp_mem.size() != 0) begin
               b = exp_mem.pop_front();
               check("mem_we", 32'(mem_we), 32'(b.we));
               check("mem_addr", mem_addr, b.addr);
               if (b.we) begin
                  check("mem_wdata", mem_wdata, b.wdata);
                  check("mem_be", 32'(mem_be), 32'(b.be));
               end
            end
         end
         if (rst_n && (mem_read_m || mem_write_m) && !cache_stall) begin
            check("retire_expected", 32'(exp_ret.size() != 0), 32'd1);
            if (exp_ret.size() != 0) begin
               r = exp_ret.pop_front();
               if (r.load) check("rdata_m", rdata_m, r.rdata);
            end
         end
      end
   end

   task automatic do_op(input string name, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int latency, input int exp_beats,
                        input logic [31:0] exp_rdata, input int exp_stall);
      int stall_cnt;
      bit done;
      beat_t b;
      ret_t  r;
      if (wr) begin
         b = '{we: 1'b1, addr: addr, wdata: wdata, be: be};
         exp_mem.push_back(b);
      end else begin
         for (int i = 0; i < exp_beats; i++) begin
            b = '{we: 1'b0, addr: (addr & ~32'hF) + 32'(4 * i), wdata: 32'h0, be: 4'h0};
            exp_mem.push_back(b);
         end
      end
      r = '{load: !wr, rdata: exp_rdata};
      exp_ret.push_back(r);
      lat = latency;
      @(posedge clk);
      #2;
      mem_read_m  = rd;
      mem_write_m = wr;
      addr_m      = addr;
      wdata_m     = wdata;
      be_m        = be;
      stall_cnt   = 0;
      done        = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #2;
         if (!cache_stall) begin
            done = 1'b1;
            break;
         end
         stall_cnt++;
      end
      check({name, "_retired"}, 32'(done), 32'd1);
      check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
      @(posedge clk);
      #2;
      mem_read_m  = 1'b0;
      mem_write_m = 1'b0;
      check({name, "_beats_left"}, 32'(exp_mem.size()), 32'd0);
      check({name, "_retire_left"}, 32'(exp_ret.size()), 32'd0);
      exp_mem.delete();
      exp_ret.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      beat_t b;
      ret_t  r;
      checks      = 0;
      failures    = 0;
      lat         = 2;
      rst_n       = 1'b0;
      mem_read_m  = 1'b0;
      mem_write_m = 1'b0;
      addr_m      = '0;
      wdata_m     = '0;
      be_m        = '0;
      for (int i = 0; i < 4; i++) begin
         img[32'h100  + 32'(4*i)] = 32'hA0 + 32'(i);
         img[32'h1100 + 32'(4*i)] = 32'hB0 + 32'(i);
         img[32'h2000 + 32'(4*i)] = 32'hC0 + 32'(i);
      end

      repeat (3) @(negedge clk);
      check("rst_stall", 32'(cache_stall), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_rdata", rdata_m, 32'h0);
      rst_n = 1'b1;

      //    name           rd wr addr         wdata          be    lat beats rdata          stall
      do_op("cold_miss",   1, 0, 32'h100,  32'h0,        4'h0, 2, 4, 32'hA0,        9);
      do_op("read_hit",    1, 0, 32'h108,  32'h0,        4'h0, 2, 0, 32'hA2,        0);
      do_op("store_hit",   0, 1, 32'h104,  32'hAABBCCDD, 4'h3, 3, 1, 32'h0,         4);
      do_op("merged_rd",   1, 0, 32'h104,  32'h0,        4'h0, 2, 0, 32'h0000CCDD,  0);
      do_op("store_both",  1, 1, 32'h108,  32'h11223344, 4'hC, 3, 1, 32'h0,         4);
      do_op("both_rd",     1, 0, 32'h108,  32'h0,        4'h0, 2, 0, 32'h112200A2,  0);
      do_op("store_miss",  0, 1, 32'h2000, 32'h12345678, 4'hF, 3, 1, 32'h0,         4);
      do_op("miss_rd",     1, 0, 32'h2000, 32'h0,        4'h0, 2, 4, 32'h12345678,  9);
      do_op("conflict",    1, 0, 32'h1100, 32'h0,        4'h0, 2, 4, 32'hB0,        9);
      do_op("evicted",     1, 0, 32'h100,  32'h0,        4'h0, 2, 4, 32'hA0,        9);
      do_op("evicted_hit", 1, 0, 32'h10C,  32'h0,        4'h0, 2, 0, 32'hA3,        0);
      do_op("other_set",   1, 0, 32'h2004, 32'h0,        4'h0, 2, 0, 32'hC1,        0);

      // Refill of 0x1100 interrupted by reset after its second beat.
      for (int i = 0; i < 4; i++) begin
         b = '{we: 1'b0, addr: 32'h1100 + 32'(4*i), wdata: 32'h0, be: 4'h0};
         exp_mem.push_back(b);
      end
      r = '{load: 1'b1, rdata: 32'hB0};
      exp_ret.push_back(r);
      lat = 2;
      @(posedge clk);
      #2;
      mem_read_m = 1'b1;
      addr_m     = 32'h1100;
      for (int i = 0; i < 100 && exp_mem.size() > 2; i++) begin
         @(negedge clk);
         #2;
      end
      check("rst_mid_progress", 32'(exp_mem.size()), 32'd2);
      @(posedge clk);
      #2;
      check("req_before_reset", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_mem_req", 32'(mem_req), 32'd0);
      check("rst_mid_mem_addr", mem_addr, 32'h0);
      check("rst_mid_stall_req", 32'(cache_stall), 32'd1);
      exp_mem.delete();
      exp_ret.delete();
      mem_read_m = 1'b0;
      #1;
      check("rst_mid_stall_idle", 32'(cache_stall), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_op("post_rst_miss", 1, 0, 32'h100, 32'h0, 4'h0, 2, 4, 32'hA0,       9);
      do_op("post_rst_hit",  1, 0, 32'h104, 32'h0, 4'h0, 2, 0, 32'h0000CCDD, 0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
